// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and the round-index type.
package aes_pkg;
  localparam int AES_BLOCK_LENGTH = 128;
  localparam int AES128_NUM_ROUNDS = 10;
  localparam int AES128_ROUND_W = $clog2(AES128_NUM_ROUNDS + 1);
  typedef logic [AES128_ROUND_W-1:0] round_idx_t;
endpackage

// File: rtl/round_key_store.sv
// round_key_store: round-key register file with one full-key write port and one slice read port.
module round_key_store #(
  parameter int BLOCK_LENGTH = 128,
  parameter int DATA_W = 32,
  parameter int NUM_ROUNDS = 10,
  localparam int RW = $clog2(NUM_ROUNDS + 1),
  localparam int BEATS = BLOCK_LENGTH / DATA_W,
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [RW-1:0]           i_wr_round,
  input  logic [BLOCK_LENGTH-1:0] i_wr_data,
  input  logic [RW-1:0]           i_rd_round,
  input  logic [BW-1:0]           i_rd_beat,
  output logic [DATA_W-1:0]       o_rd_data
);
  logic [BLOCK_LENGTH-1:0] r_keys [NUM_ROUNDS+1];
  logic [BLOCK_LENGTH-1:0] w_row;
  logic [BLOCK_LENGTH-1:0] w_shift;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i <= NUM_ROUNDS; i++) r_keys[i] <= '0;
    else if (i_wr_en && i_wr_round <= RW'(NUM_ROUNDS))
      r_keys[i_wr_round] <= i_wr_data;
  // out-of-range rounds read as an all-zero key so data passes through
  assign w_row = i_rd_round <= RW'(NUM_ROUNDS) ? r_keys[i_rd_round] : '0;
  assign w_shift = w_row << (i_rd_beat * DATA_W);
  assign o_rd_data = w_shift[BLOCK_LENGTH-1 -: DATA_W];
endmodule

// File: rtl/add_round_key_stream.sv
// add_round_key_stream: streaming AES AddRoundKey, XORs MSB-first state slices with the selected round key.
module add_round_key_stream
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = AES_BLOCK_LENGTH,
  parameter int DATA_W = 32,
  parameter int NUM_ROUNDS = AES128_NUM_ROUNDS,
  localparam int RW = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_wr_en,
  input  logic [RW-1:0]           key_wr_round,
  input  logic [BLOCK_LENGTH-1:0] key_wr_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [RW-1:0]           in_round,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    out_err
);
  localparam int BEATS = BLOCK_LENGTH / DATA_W;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [BW-1:0]     r_beat;
  logic [RW-1:0]     r_round;
  logic [RW-1:0]     w_round;
  logic [DATA_W-1:0] w_key;
  logic              w_xfer;
  logic              w_first;
  logic              w_last;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_err;
  assign in_ready = !r_valid || out_ready;
  assign w_xfer = in_valid && in_ready;
  assign w_first = r_beat == '0;
  assign w_last = r_beat == BW'(BEATS - 1);
  // beat 0 uses the live index; later beats use the one latched with beat 0
  assign w_round = w_first ? in_round : r_round;
  round_key_store #(
    .BLOCK_LENGTH(BLOCK_LENGTH),
    .DATA_W(DATA_W),
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_store (
    .clk(clk),
    .rst(rst),
    .i_wr_en(key_wr_en),
    .i_wr_round(key_wr_round),
    .i_wr_data(key_wr_data),
    .i_rd_round(w_round),
    .i_rd_beat(r_beat),
    .o_rd_data(w_key)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_beat <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
      r_err <= 1'b0;
    end else if (w_xfer) begin
      r_beat <= w_last ? '0 : r_beat + BW'(1);
      if (w_first) r_round <= in_round;
      r_valid <= 1'b1;
      r_data <= in_data ^ w_key;
      r_last <= w_last;
      r_err <= w_round > RW'(NUM_ROUNDS);
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  assign out_valid = r_valid;
  assign out_data = r_data;
  assign out_last = r_last;
  assign out_err = r_err;
endmodule

// File: tb/tb_add_round_key_stream.sv
// tb_add_round_key_stream: scoreboard bench for 32-bit and 128-bit slice configurations.
module tb_add_round_key_stream;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic key_wr_en = 0;
  logic [3:0] key_wr_round = 0;
  logic [127:0] key_wr_data = 0;
  logic in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic [3:0] in_round = 0;
  logic in_ready, out_valid, out_last, out_err;
  logic [31:0] out_data;
  logic b_in_valid = 0, b_out_ready = 1;
  logic [127:0] b_in_data = 0;
  logic [3:0] b_in_round = 0;
  logic b_in_ready, b_out_valid, b_out_last, b_out_err;
  logic [127:0] b_out_data;

  add_round_key_stream #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_round(key_wr_round), .key_wr_data(key_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_err(out_err)
  );
  add_round_key_stream #(.DATA_W(128)) dut_w (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_round(key_wr_round), .key_wr_data(key_wr_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_round(b_in_round),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last), .out_err(b_out_err)
  );

  int checks = 0, errors = 0;
  logic [33:0] q32[$];
  logic [129:0] q128[$];
  logic [127:0] mk[16];
  int mbeat = 0;
  logic [3:0] mround = 0;
  bit bp = 0;

  task automatic chk(input string tag, input logic [129:0] got, input logic [129:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [33:0] held, e32;
  logic [129:0] e128;
  bit stall_prev = 0;
  always @(negedge clk)
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev) chk("hold", {out_err, out_last, out_data}, held);
      stall_prev = out_valid && !out_ready;
      held = {out_err, out_last, out_data};
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (q32.size() == 0) chk("extra32", 1, 0);
        else begin
          e32 = q32.pop_front();
          chk("out32", {out_err, out_last, out_data}, e32);
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (q128.size() == 0) chk("extra128", 1, 0);
        else begin
          e128 = q128.pop_front();
          chk("out128", {b_out_err, b_out_last, b_out_data}, e128);
        end
      end
    end

  always @(posedge clk)
    if (bp) begin
      #2;
      out_ready = $urandom_range(0, 3) != 0;
    end

  task automatic model_key();
    if (key_wr_en && key_wr_round <= 10) mk[key_wr_round] = key_wr_data;
  endtask

  task automatic send32(input logic [31:0] d, input logic [3:0] r, input bit kw = 0,
                        input logic [3:0] ks = 0, input logic [127:0] kd = 0);
    bit acc = 0;
    logic [3:0] rr;
    logic [127:0] key;
    in_valid = 1; in_data = d; in_round = r;
    key_wr_en = kw; key_wr_round = ks; key_wr_data = kd;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        rr = mbeat == 0 ? r : mround;
        if (mbeat == 0) mround = r;
        key = rr <= 10 ? mk[rr] : '0;
        q32.push_back({rr > 10, mbeat == 3, d ^ key[127 - mbeat*32 -: 32]});
        mbeat = (mbeat + 1) % 4;
      end
      model_key();
      @(posedge clk); #1;
      key_wr_en = 0;
    end
    if (!acc) chk("accept32", 0, 1);
    in_valid = 0;
  endtask

  task automatic send128(input logic [127:0] d, input logic [3:0] r);
    bit acc = 0;
    b_in_valid = 1; b_in_data = d; b_in_round = r;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = b_in_ready;
      if (acc) q128.push_back({r > 10, 1'b1, d ^ (r <= 10 ? mk[r] : 128'h0)});
      @(posedge clk); #1;
    end
    if (!acc) chk("accept128", 0, 1);
    b_in_valid = 0;
  endtask

  task automatic wrkey(input logic [3:0] s, input logic [127:0] k);
    key_wr_en = 1; key_wr_round = s; key_wr_data = k;
    @(negedge clk);
    model_key();
    @(posedge clk); #1;
    key_wr_en = 0;
  endtask

  logic [127:0] st = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] k0 = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] k1a = 128'h11111111222222223333333344444444;
  logic [127:0] k1b = 128'haaaaaaaabbbbbbbbccccccccdddddddd;
  logic [127:0] rs;
  logic [32:0] exp35[4] = '{{1'b0, 32'h00102030}, {1'b0, 32'h40506070}, {1'b0, 32'h8090a0b0}, {1'b1, 32'hc0d0e0f0}};

  initial begin
    for (int i = 0; i < 16; i++) mk[i] = '0;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    chk("rst_out", {out_valid, out_err, out_last, out_data}, 0);
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    @(negedge clk);
    chk("rel_rdy", in_ready, 1);
    @(posedge clk); #1;
    wrkey(0, k0);
    send128(st, 0);
    chk("wide", {b_out_valid, b_out_last, b_out_data}, {2'b11, 128'h00102030405060708090a0b0c0d0e0f0});
    send128(st, 11);
    chk("wide_err", {b_out_err, b_out_data}, {1'b1, st});
    for (int b = 0; b < 4; b++) begin
      send32(st[127 - b*32 -: 32], 0);
      chk("nobubble", out_valid, 1);
      chk("vec32", {out_last, out_data}, exp35[b]);
    end
    send32(st[127:96], 0);
    out_ready = 0;
    in_valid = 1; in_data = st[95:64];
    repeat (3) begin
      @(negedge clk);
      chk("stall_rdy", in_ready, 0);
      chk("stall_data", out_data, 32'h00102030);
      @(posedge clk); #1;
    end
    out_ready = 1;
    for (int b = 1; b < 4; b++) send32(st[127 - b*32 -: 32], 0);
    for (int b = 0; b < 4; b++) begin
      send32(st[127 - b*32 -: 32], b == 0 ? 4'd11 : 4'd0);
      chk("err_beat", {out_err, out_data}, {1'b1, st[127 - b*32 -: 32]});
    end
    send32(st[127:96], 0);
    chk("err_clear", {out_err, out_data}, {1'b0, 32'h00102030});
    for (int b = 1; b < 4; b++) send32(st[127 - b*32 -: 32], 0);
    wrkey(1, k1a);
    send32(st[127:96], 1);
    send32(st[95:64], 5);
    send32(st[63:32], 7, 1, 1, k1b);
    chk("old_key", out_data, st[63:32] ^ k1a[63:32]);
    send32(st[31:0], 0);
    chk("new_key", {out_last, out_data}, {1'b1, st[31:0] ^ k1b[31:0]});
    bp = 1;
    for (int blk = 0; blk < 6; blk++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < 4; b++)
        send32(rs[127 - b*32 -: 32], 4'($urandom_range(0, 12)), $urandom_range(0, 3) == 0,
               4'($urandom_range(0, 11)), {$urandom, $urandom, $urandom, $urandom});
    end
    bp = 0;
    @(posedge clk); #3;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    send32(st[127:96], 0);
    send32(st[95:64], 0);
    rst = 1;
    #1;
    chk("rst_mid", {out_valid, out_err, out_last, out_data}, 0);
    chk("rst_mid_rdy", in_ready, 1);
    q32.delete(); q128.delete();
    mbeat = 0; mround = 0;
    for (int i = 0; i < 16; i++) mk[i] = '0;
    @(posedge clk); #1;
    rst = 0;
    send32(st[127:96], 0);
    chk("post_rst", {out_last, out_data}, {1'b0, st[127:96]});
    for (int b = 1; b < 4; b++) send32(st[127 - b*32 -: 32], 0);
    chk("post_last", {out_last, out_data}, {1'b1, st[31:0]});
    for (int n = 0; n < 20 && (q32.size() != 0 || q128.size() != 0); n++) @(posedge clk);
    @(negedge clk);
    chk("drain32", q32.size(), 0);
    chk("drain128", q128.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_round_key_stream.md
ADD_ROUND_KEY_STREAM -- requirements
Module: add_round_key_stream

Interface
REQ-001 The block SHALL have parameter BLOCK_LENGTH, default 128, AES block width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, slice width per beat; it must divide BLOCK_LENGTH (32/64/128 supported).
REQ-003 The block SHALL have parameter NUM_ROUNDS, default 10, giving NUM_ROUNDS+1 stored round keys.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_wr_en  input  1  write one full round key this cycle.
REQ-007 key_wr_round  input  $clog2(NUM_ROUNDS+1)  round-key slot to write.
REQ-008 key_wr_data  input  BLOCK_LENGTH  round-key value.
REQ-009 in_valid  input  1  input slice valid.
REQ-010 in_ready  output  1  block can accept a slice.
REQ-011 in_data  input  DATA_W  state slice.
REQ-012 in_round  input  $clog2(NUM_ROUNDS+1)  round index, sampled on the first beat of a block only.
REQ-013 out_valid  output  1  output slice valid.
REQ-014 out_ready  input  1  downstream accepts slice.
REQ-015 out_data  output  DATA_W  state slice XOR key slice.
REQ-016 out_last  output  1  final slice of the block.
REQ-017 out_err  output  1  block used an out-of-range round index.

Function
REQ-018 A block SHALL be BEATS = BLOCK_LENGTH/DATA_W slices, beat 0 carrying bits [BLOCK_LENGTH-1 -: DATA_W] (MSB first).
REQ-019 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer when out_valid and out_ready are both high.
REQ-020 in_ready SHALL equal !out_valid || out_ready (single output register, full throughput, no combinational in_valid-to-out path).
REQ-021 out_data SHALL equal in_data XOR key slice of the same beat index, registered: 1-cycle latency from input transfer to out_valid.
REQ-022 A beat counter SHALL increment on each input transfer and wrap from BEATS-1 to 0; out_last SHALL be high for the beat-(BEATS-1) output.
REQ-023 On beat 0 the round index SHALL be latched; beats 0..BEATS-1 of that block SHALL use the latched index, ignoring later in_round values.
REQ-024 If the round index exceeds NUM_ROUNDS, key slice SHALL be treated as zero (data passes unchanged) and out_err SHALL be high on every beat of that block.
REQ-025 Output register SHALL hold data, last and err stable while out_valid && !out_ready.
REQ-026 Key writes SHALL take effect on the next cycle; a beat transferred in the same cycle as a write to its slot SHALL use the old key.
REQ-027 Key writes SHALL be accepted in any cycle, including mid-block; subsequent beats of that block use the new value.
REQ-028 When DATA_W equals BLOCK_LENGTH, BEATS SHALL be 1 and out_last SHALL be high on every output.

Reset
REQ-029 On rst high: out_valid=0, out_data=0, out_last=0, out_err=0, beat counter=0, latched round=0, all key slots=0.
REQ-030 Reset mid-block SHALL discard the partial block; the next accepted beat is beat 0.
REQ-031 in_ready SHALL be 1 while reset is asserted and after release.

Structure
REQ-032 Shared package aes_pkg SHALL hold AES_BLOCK_LENGTH=128, AES128_NUM_ROUNDS=10 and the round-index typedef.
REQ-033 One sub-module SHALL be natural: round_key_store (NUM_ROUNDS+1 x BLOCK_LENGTH register file, one write port, one slice read port addressed by round and beat).

Verification
REQ-034 DATA_W=128, key slot 0=000102030405060708090a0b0c0d0e0f, in_data=00112233445566778899aabbccddeeff, round 0 -> out_data=00102030405060708090a0b0c0d0e0f0, out_last=1, one cycle later.
REQ-035 DATA_W=32, same vectors, 4 back-to-back beats -> outputs 00102030, 40506070, 8090a0b0, c0d0e0f0, out_last only on 4th, no bubbles.
REQ-036 DATA_W=32, out_ready held low 3 cycles after first output -> in_ready low, out_data stable at 00102030, no loss or duplication on release.
REQ-037 in_round=11 with NUM_ROUNDS=10 -> out_data equals in_data, out_err=1 all 4 beats; next block round 0 -> out_err=0.
REQ-038 Key write to slot 1 in same cycle as beat 2 of a round-1 block -> beat 2 uses old key, beat 3 uses new key.
REQ-039 rst asserted after beat 1 of a block -> out_valid=0 immediately, keys=0, next beat treated as beat 0.
